// File: rtl/oled_spi_pkg.sv
// Shared constants and types for the AHB-Lite OLED SPI controller:
// register offsets, register bit positions and shift-engine states.
package oled_spi_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RES    = 2'd3;

    localparam int unsigned TXD_DC_BIT     = 8;
    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_DIV_LSB   = 1;
    localparam int unsigned CTRL_FLUSH_BIT = 31;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_EMPTY_BIT = 2;
    localparam int unsigned STAT_OVF_BIT   = 3;
    localparam int unsigned STAT_LEVEL_LSB = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLow,
        StHigh,
        StHold
    } spi_state_e;

endpackage

// File: rtl/oled_spi_fifo.sv
// Synchronous TX FIFO with flush and fill level. Read data is first-word
// fall-through; flush takes priority over a simultaneous push or pop.
module oled_spi_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 9,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push-while-full is accepted then.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ahblite_oled_spi.sv
// AHB-Lite slave with a FIFO-fed SPI shift engine for an SSD1306-class OLED
// (SCLK/SDIN/DC/CS_N) plus a software-controlled panel reset pin.
module ahblite_oled_spi
    import oled_spi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        OLED_SCLK,
    output logic        OLED_SDIN,
    output logic        OLED_DC,
    output logic        OLED_CS_N,
    output logic        OLED_RES_N
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic             dphase_q;
    logic             dwrite_q;
    logic [1:0]       daddr_q;
    logic             en_q;
    logic [DIV_W-1:0] div_q;
    logic             ovf_q;
    logic             res_q;

    logic             trans_en;
    logic             wr_en;
    logic             push;
    logic             flush;
    logic             pop;
    logic [8:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LW-1:0]    fifo_level;

    spi_state_e       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_lat_q, div_lat_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       sh_q, sh_d;
    logic [8:0]       pend_q, pend_d;
    logic             sclk_q, sclk_d;
    logic             sdin_q, sdin_d;
    logic             dc_q, dc_d;
    logic             cs_n_q, cs_n_d;
    logic             half_done;

    logic             unused_ahb;
    assign unused_ahb = ^{HSIZE, HPROT, HADDR, HTRANS, HWDATA};

    assign trans_en = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dphase_q <= 1'b0;
            dwrite_q <= 1'b0;
            daddr_q  <= '0;
        end else begin
            dphase_q <= trans_en;
            if (trans_en) begin
                dwrite_q <= HWRITE;
                daddr_q  <= HADDR[3:2];
            end
        end
    end

    assign wr_en = dphase_q & dwrite_q;
    assign push  = wr_en & (daddr_q == REG_TXDATA);
    assign flush = wr_en & (daddr_q == REG_CTRL) & HWDATA[CTRL_FLUSH_BIT];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            en_q  <= 1'b0;
            div_q <= DIV_W'(DEFAULT_DIV);
            ovf_q <= 1'b0;
            res_q <= 1'b0;
        end else begin
            if (wr_en && daddr_q == REG_CTRL) begin
                en_q  <= HWDATA[CTRL_EN_BIT];
                div_q <= HWDATA[CTRL_DIV_LSB +: DIV_W];
            end
            if (wr_en && daddr_q == REG_RES) begin
                res_q <= HWDATA[0];
            end
            if (wr_en && daddr_q == REG_STATUS && HWDATA[STAT_OVF_BIT]) begin
                ovf_q <= 1'b0;
            end else if (push && fifo_full && !pop && !flush) begin
                ovf_q <= 1'b1;
            end
        end
    end

    oled_spi_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (push),
        .wdata_i (HWDATA[TXD_DC_BIT:0]),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_lat_q <= '0;
            bitcnt_q  <= '0;
            sh_q      <= '0;
            pend_q    <= '0;
            sclk_q    <= 1'b0;
            sdin_q    <= 1'b0;
            dc_q      <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_lat_q <= div_lat_d;
            bitcnt_q  <= bitcnt_d;
            sh_q      <= sh_d;
            pend_q    <= pend_d;
            sclk_q    <= sclk_d;
            sdin_q    <= sdin_d;
            dc_q      <= dc_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign half_done = (cnt_q == div_lat_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_lat_d = div_lat_q;
        bitcnt_d  = bitcnt_q;
        sh_d      = sh_q;
        pend_d    = pend_q;
        sclk_d    = sclk_q;
        sdin_d    = sdin_q;
        dc_d      = dc_q;
        cs_n_d    = cs_n_q;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                if (en_q && !fifo_empty) begin
                    pop     = 1'b1;
                    pend_d  = fifo_rdata;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                sh_d      = pend_q[7:0];
                bitcnt_d  = 3'd7;
                dc_d      = pend_q[8];
                cs_n_d    = 1'b0;
                sdin_d    = pend_q[7];
                cnt_d     = '0;
                // Divider is latched per byte so CTRL writes never stretch a byte.
                div_lat_d = div_q;
                state_d   = StLow;
            end
            StLow: begin
                if (half_done) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = StHigh;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            StHigh: begin
                if (half_done) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bitcnt_q != 3'd0) begin
                        sh_d     = {sh_q[6:0], 1'b0};
                        sdin_d   = sh_q[6];
                        bitcnt_d = bitcnt_q - 3'd1;
                        state_d  = StLow;
                    end else if (en_q && !fifo_empty) begin
                        pop     = 1'b1;
                        pend_d  = fifo_rdata;
                        state_d = StLoad;
                    end else begin
                        state_d = StHold;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            StHold: begin
                if (half_done) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        HRDATA = '0;
        case (daddr_q)
            REG_CTRL: begin
                HRDATA[CTRL_EN_BIT]             = en_q;
                HRDATA[CTRL_DIV_LSB +: DIV_W]   = div_q;
            end
            REG_STATUS: begin
                HRDATA[STAT_BUSY_BIT]           = (state_q != StIdle);
                HRDATA[STAT_FULL_BIT]           = fifo_full;
                HRDATA[STAT_EMPTY_BIT]          = fifo_empty;
                HRDATA[STAT_OVF_BIT]            = ovf_q;
                HRDATA[STAT_LEVEL_LSB +: LW]    = fifo_level;
            end
            REG_RES: HRDATA[0] = res_q;
            default: HRDATA = '0;
        endcase
    end

    assign HREADYOUT  = 1'b1;
    assign HRESP      = 2'b00;
    assign OLED_SCLK  = sclk_q;
    assign OLED_SDIN  = sdin_q;
    assign OLED_DC    = dc_q;
    assign OLED_CS_N  = cs_n_q;
    assign OLED_RES_N = res_q;

endmodule

// File: tb/tb_ahblite_oled_spi.sv
// Bench for ahblite_oled_spi: AHB-Lite register traffic plus an SPI receiver
// model that decodes frames and measures SCLK/CS_N timing.
module tb_ahblite_oled_spi;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned DEF_DIV = 4;
    localparam logic [3:0] A_TXD  = 4'h0;
    localparam logic [3:0] A_CTRL = 4'h4;
    localparam logic [3:0] A_STAT = 4'h8;
    localparam logic [3:0] A_RES  = 4'hC;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic        OLED_SCLK, OLED_SDIN, OLED_DC, OLED_CS_N, OLED_RES_N;

    always #5 HCLK = ~HCLK;

    ahblite_oled_spi #(
        .FIFO_DEPTH  (DEPTH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HPROT      (HPROT),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP),
        .OLED_SCLK  (OLED_SCLK),
        .OLED_SDIN  (OLED_SDIN),
        .OLED_DC    (OLED_DC),
        .OLED_CS_N  (OLED_CS_N),
        .OLED_RES_N (OLED_RES_N)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI receiver model: decodes bytes on SCLK rises, measures phase lengths.
    logic [8:0] rx_q[$];
    int   exp_hp = 2;
    int   m_bits = 0;
    logic [7:0] m_sh = '0;
    logic prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_dc = 1'b0;
    int   high_len = 0, low_len = 0, cs_low_len = 0, last_cs_low = 0;
    int   rises = 0, cs_falls = 0, hp_err = 0, dc_err = 0, frame_err = 0;

    always @(posedge HCLK) begin
        #2;
        if (!HRESETn) begin
            m_bits = 0;
        end else begin
            if (prev_dc !== OLED_DC && (OLED_SCLK || m_bits != 0)) dc_err++;
            if (prev_cs_n === 1'b1 && OLED_CS_N === 1'b0) begin
                cs_falls++;
                cs_low_len = 0;
            end
            if (prev_cs_n === 1'b0 && OLED_CS_N === 1'b1) begin
                last_cs_low = cs_low_len;
                if (m_bits != 0) frame_err++;
            end
            if (prev_sclk === 1'b0 && OLED_SCLK === 1'b1) begin
                rises++;
                if (OLED_CS_N !== 1'b0) frame_err++;
                if (m_bits != 0 && low_len != exp_hp) hp_err++;
                m_sh = {m_sh[6:0], OLED_SDIN};
                m_bits++;
                high_len = 0;
                if (m_bits == 8) begin
                    rx_q.push_back({OLED_DC, m_sh});
                    m_bits = 0;
                end
            end
            if (prev_sclk === 1'b1 && OLED_SCLK === 1'b0) begin
                if (high_len != exp_hp) hp_err++;
                low_len = 0;
            end
            if (OLED_SCLK) high_len++;
            else low_len++;
            if (!OLED_CS_N) cs_low_len++;
        end
        prev_sclk = OLED_SCLK;
        prev_cs_n = OLED_CS_N;
        prev_dc   = OLED_DC;
    end

    task automatic clear_mon();
        rx_q.delete();
        rises = 0; cs_falls = 0; hp_err = 0; dc_err = 0; frame_err = 0; last_cs_low = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4002_0000 | 32'(addr);
        tick(1);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        tick(1);
    endtask

    task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4002_0000 | 32'(addr);
        tick(1);
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
        tick(1);
    endtask

    function automatic logic [31:0] status_word(input bit busy, input bit full, input bit empty,
                                                input bit ovf, input int level);
        return (32'(level) << 4) | (32'(ovf) << 3) | (32'(empty) << 2) | (32'(full) << 1)
               | 32'(busy);
    endfunction

    task automatic wait_rx(input int n, input int budget);
        int i = 0;
        while (rx_q.size() < n && i < budget) begin
            tick(1);
            i++;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic [31:0] s;
        int i = 0;
        ahb_read(A_STAT, s);
        while (s[0] && i < budget) begin
            ahb_read(A_STAT, s);
            i++;
        end
        check(tag, 32'(s[0]), 32'd0);
    endtask

    task automatic compare_stream(input string tag, input logic [8:0] exp_q[$]);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [8:0]  exp_q[$];
        logic [8:0]  mq[$];
        bit          ovf_m;
        int          div, k;

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'd2;
        HPROT = 4'h3; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1;
        tick(2);
        HRESETn = 1'b1;
        tick(1);

        // Reset state
        check("rst_sclk", 32'(OLED_SCLK), 32'd0);
        check("rst_cs_n", 32'(OLED_CS_N), 32'd1);
        check("rst_res_n", 32'(OLED_RES_N), 32'd0);
        check("rst_dc", 32'(OLED_DC), 32'd0);
        check("hreadyout", 32'(HREADYOUT), 32'd1);
        check("hresp", 32'(HRESP), 32'd0);
        ahb_read(A_STAT, rd);
        check("rst_status", rd, 32'h4);
        ahb_read(A_CTRL, rd);
        check("rst_ctrl", rd, 32'(DEF_DIV) << 1);

        // RES register and TXDATA read-as-zero
        ahb_write(A_RES, 32'h1);
        check("res_n_set", 32'(OLED_RES_N), 32'd1);
        ahb_read(A_RES, rd);
        check("res_read", rd, 32'h1);
        ahb_read(A_TXD, rd);
        check("txdata_read", rd, 32'h0);

        // Single byte with latency and timing, DIV=1
        clear_mon();
        exp_hp = 2;
        ahb_write(A_CTRL, 32'h3);
        ahb_write(A_TXD, 32'h1A5);
        check("lat_cs_n_n1", 32'(OLED_CS_N), 32'd1);
        tick(1);
        check("lat_cs_n_n2", 32'(OLED_CS_N), 32'd1);
        tick(1);
        check("lat_cs_n_n3", 32'(OLED_CS_N), 32'd0);
        check("lat_dc", 32'(OLED_DC), 32'd1);
        check("lat_sdin_msb", 32'(OLED_SDIN), 32'd1);
        wait_rx(1, 200);
        exp_q = '{9'h1A5};
        compare_stream("single", exp_q);
        wait_idle("single_idle", 50);
        check("single_cs_high", 32'(OLED_CS_N), 32'd1);
        check("single_cs_low_len", 32'(last_cs_low), 32'd34);
        check("single_rises", 32'(rises), 32'd8);
        check("single_hp_err", 32'(hp_err), 32'd0);

        // Back-to-back: CS_N stays low, DC switches in LOAD
        clear_mon();
        ahb_write(A_TXD, 32'h0AE);
        ahb_write(A_TXD, 32'h1FF);
        wait_rx(2, 300);
        wait_idle("b2b_idle", 50);
        exp_q = '{9'h0AE, 9'h1FF};
        compare_stream("b2b", exp_q);
        check("b2b_cs_falls", 32'(cs_falls), 32'd1);
        check("b2b_rises", 32'(rises), 32'd16);
        check("b2b_cs_low_len", 32'(last_cs_low), 32'(2 * 16 * 2 + 1 + 2));
        check("b2b_dc_err", 32'(dc_err), 32'd0);
        check("b2b_hp_err", 32'(hp_err), 32'd0);

        // Overflow with EN=0, then drain
        clear_mon();
        ahb_write(A_CTRL, 32'h2);
        mq.delete();
        ovf_m = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [8:0] v;
            v = 9'($urandom);
            if (mq.size() < DEPTH) mq.push_back(v);
            else ovf_m = 1'b1;
            ahb_write(A_TXD, 32'(v));
        end
        ahb_read(A_STAT, rd);
        check("ovf_status", rd, status_word(0, mq.size() == DEPTH, mq.size() == 0, ovf_m,
                                            mq.size()));
        ahb_write(A_STAT, 32'h8);
        ahb_read(A_STAT, rd);
        check("ovf_cleared", rd, status_word(0, 1, 0, 0, mq.size()));
        ahb_write(A_CTRL, 32'h3);
        wait_rx(DEPTH, DEPTH * 40 + 200);
        wait_idle("ovf_idle", 50);
        tick(40);
        compare_stream("ovf_drain", mq);
        ahb_read(A_STAT, rd);
        check("ovf_drained_status", rd, 32'h4);

        // EN cleared mid-byte, then flush
        clear_mon();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            logic [8:0] v;
            v = 9'($urandom);
            exp_q.push_back(v);
            ahb_write(A_TXD, 32'(v));
        end
        for (int i = 0; i < 100 && rises == 0; i++) tick(1);
        ahb_write(A_CTRL, 32'h2);
        wait_idle("en_off_idle", 50);
        exp_q = exp_q[0:0];
        compare_stream("en_off", exp_q);
        ahb_read(A_STAT, rd);
        check("en_off_level3", rd, status_word(0, 0, 0, 0, 3));
        ahb_write(A_CTRL, 32'h8000_0002);
        ahb_read(A_STAT, rd);
        check("flush_empty", rd, 32'h4);
        ahb_read(A_CTRL, rd);
        check("flush_bit_reads0", rd, 32'h2);
        ahb_write(A_CTRL, 32'h3);
        tick(100);
        check("flush_nothing_sent", 32'(rx_q.size()), 32'd1);

        // Randomised batches against the queue model
        for (int r = 0; r < 6; r++) begin
            div = $urandom_range(0, 3);
            k   = $urandom_range(2, DEPTH);
            clear_mon();
            exp_hp = div + 1;
            exp_q.delete();
            ahb_write(A_CTRL, 32'((div << 1) | 1));
            for (int i = 0; i < k; i++) begin
                logic [8:0] v;
                v = 9'($urandom);
                exp_q.push_back(v);
                ahb_write(A_TXD, 32'(v));
            end
            wait_rx(k, k * (2 + 16 * (div + 1)) + 100);
            wait_idle($sformatf("rnd%0d_idle", r), 50);
            compare_stream($sformatf("rnd%0d", r), exp_q);
            check($sformatf("rnd%0d_cs_falls", r), 32'(cs_falls), 32'd1);
            check($sformatf("rnd%0d_cs_low_len", r), 32'(last_cs_low),
                  32'(k * 16 * (div + 1) + (k - 1) + (div + 1)));
            check($sformatf("rnd%0d_timing", r), 32'(hp_err + dc_err + frame_err), 32'd0);
        end

        // Reset in the middle of a byte
        clear_mon();
        exp_hp = 2;
        ahb_write(A_RES, 32'h1);
        ahb_write(A_CTRL, 32'h3);
        for (int i = 0; i < 3; i++) ahb_write(A_TXD, 32'($urandom_range(0, 511)));
        for (int i = 0; i < 100 && OLED_SCLK !== 1'b1; i++) tick(1);
        check("mid_rst_sclk_high", 32'(OLED_SCLK), 32'd1);
        HRESETn = 1'b0;
        tick(1);
        check("mid_rst_cs_n", 32'(OLED_CS_N), 32'd1);
        check("mid_rst_sclk", 32'(OLED_SCLK), 32'd0);
        check("mid_rst_res_n", 32'(OLED_RES_N), 32'd0);
        tick(1);
        HRESETn = 1'b1;
        clear_mon();
        ahb_read(A_STAT, rd);
        check("mid_rst_status", rd, 32'h4);
        ahb_read(A_CTRL, rd);
        check("mid_rst_ctrl", rd, 32'(DEF_DIV) << 1);
        tick(100);
        check("mid_rst_no_tx", 32'(rx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
